// File: rtl/pipe_adder_if.sv
// pipe_adder_if -- operand/result handshake bundle for pipe_adder.
//   master : drives in_valid/in1/in2/c_in[/sub] and out_ready;
//            observes in_ready, out_valid, sum, c_out, overflow.
//   slave  : the adder side of the same signals.
// Optional macro SUB_MODE_EN adds the subtract-select signal "sub".
interface pipe_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
`ifdef SUB_MODE_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

`ifdef SUB_MODE_EN
  modport master (
    output in_valid, in1, in2, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );
  modport slave (
    input  in_valid, in1, in2, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
`else
  modport master (
    output in_valid, in1, in2, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );
  modport slave (
    input  in_valid, in1, in2, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
`endif
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder -- STAGES-deep ripple-carry pipelined adder with valid/ready flow.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : pipe_adder_if.slave (operand beat in, result beat out)
// Stage k adds operand bits [k*SEG +: SEG] with the registered carry of
// stage k-1. The whole pipe advances together; it freezes only while a
// result is presented and not taken (in_ready mirrors the advance enable).
// Optional macro SUB_MODE_EN: sub=1 computes in1 - in2 (B inverted, carry-in 1).
module pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic        clock,
  input logic        reset,
  pipe_adder_if.slave bus
);
  localparam int unsigned SEG = WIDTH / STAGES;

  // Stage registers.
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic             cy_q [STAGES];
  logic             v_q  [STAGES];

  // Chain view: index 0 is the input beat, index k+1 is stage k's register.
  // This lets stage k read "its predecessor" as index k with no special case.
  logic [WIDTH-1:0] a_c  [STAGES+1];
  logic [WIDTH-1:0] b_c  [STAGES+1];
  logic [WIDTH-1:0] s_c  [STAGES+1];
  logic             cy_c [STAGES+1];
  logic             v_c  [STAGES+1];

  logic [WIDTH-1:0] s_d    [STAGES];
  logic             cy_d   [STAGES];
  logic [SEG:0]     seg_sum[STAGES];

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             adv;

  always_comb begin
`ifdef SUB_MODE_EN
    b_eff = bus.sub ? ~bus.in2 : bus.in2;
    c_eff = bus.sub ? 1'b1 : bus.c_in;
`else
    b_eff = bus.in2;
    c_eff = bus.c_in;
`endif
  end

  always_comb begin
    a_c[0]  = bus.in1;
    b_c[0]  = b_eff;
    s_c[0]  = '0;
    cy_c[0] = c_eff;
    v_c[0]  = bus.in_valid;
    for (int unsigned k = 0; k < STAGES; k++) begin
      a_c[k+1]  = a_q[k];
      b_c[k+1]  = b_q[k];
      s_c[k+1]  = s_q[k];
      cy_c[k+1] = cy_q[k];
      v_c[k+1]  = v_q[k];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, a_c[k][k*SEG +: SEG]}
                 + {1'b0, b_c[k][k*SEG +: SEG]}
                 + (SEG+1)'(cy_c[k]);
      s_d[k] = s_c[k];
      s_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      cy_d[k] = seg_sum[k][SEG];
    end
  end

  assign adv = !(v_c[STAGES] && !bus.out_ready);

  // Bubbles advance only their valid bit; data registers keep the last
  // real beat so idle inputs never disturb the visible result.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        cy_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_c[k];
        if (v_c[k]) begin
          a_q[k]  <= a_c[k];
          b_q[k]  <= b_c[k];
          s_q[k]  <= s_d[k];
          cy_q[k] <= cy_d[k];
        end
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_c[STAGES];
  assign bus.sum       = s_c[STAGES];
  assign bus.c_out     = cy_c[STAGES];
  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  assign bus.overflow  = a_c[STAGES][WIDTH-1] ^ b_c[STAGES][WIDTH-1]
                       ^ s_c[STAGES][WIDTH-1] ^ cy_c[STAGES];
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder -- self-checking bench for pipe_adder (WIDTH=16, STAGES=4).
// Honours SUB_MODE_EN when defined.
module tb_pipe_adder;
  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sub_drv = 1'b0;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(W)) bus ();
  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (.clock(clk), .reset(rst), .bus(bus));

`ifdef SUB_MODE_EN
  assign bus.sub = sub_drv;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
    int           stl;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int consumed = 0;
  logic [W-1:0] last_sum = '0, prev_sum = '0;
  logic last_c = 1'b0, last_v = 1'b0, prev_c = 1'b0, prev_v = 1'b0;
  int last_cyc = 0, prev_cyc = 0;
  logic was_stall = 1'b0;
  logic [W-1:0] hold_sum = '0;
  logic hold_c = 1'b0, hold_v = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer add; overflow = like-signed operands, different-signed result.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    exp_t e;
    logic [W-1:0] bb;
    int unsigned t;
    bb = sb ? ~b : b;
    t = int'(a) + int'(bb) + (sb ? 1 : int'(ci));
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
    e.acc = 0;
    e.stl = 0;
    return e;
  endfunction

  // Monitor: samples mid-cycle, where handshake signals are stable.
  always @(negedge clk) begin
    exp_t e;
    logic sb;
    cyc++;
    if (rst) begin
      q.delete();
      was_stall = 1'b0;
    end else begin
      check("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      check("spurious_valid", 64'(bus.out_valid && q.size() == 0), 64'(0));
      if (was_stall) begin
        check("hold_sum", 64'(bus.sum), 64'(hold_sum));
        check("hold_c_out", 64'(bus.c_out), 64'(hold_c));
        check("hold_ovf", 64'(bus.overflow), 64'(hold_v));
        check("hold_valid", 64'(bus.out_valid), 64'(1));
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        e = q.pop_front();
        check("sum", 64'(bus.sum), 64'(e.s));
        check("c_out", 64'(bus.c_out), 64'(e.c));
        check("overflow", 64'(bus.overflow), 64'(e.v));
        check("latency", 64'(cyc - e.acc - (stall_cnt - e.stl)), 64'(S));
        prev_sum = last_sum; prev_c = last_c; prev_v = last_v; prev_cyc = last_cyc;
        last_sum = bus.sum; last_c = bus.c_out; last_v = bus.overflow; last_cyc = cyc;
        consumed++;
      end
      was_stall = bus.out_valid && !bus.out_ready;
      if (was_stall) begin
        stall_cnt++;
        hold_sum = bus.sum; hold_c = bus.c_out; hold_v = bus.overflow;
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef SUB_MODE_EN
        sb = sub_drv;
`else
        sb = 1'b0;
`endif
        e = model(bus.in1, bus.in2, bus.c_in, sb);
        e.acc = cyc;
        e.stl = stall_cnt;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sb);
    logic ok;
    bus.in_valid = 1'b1;
    bus.in1 = a;
    bus.in2 = b;
    bus.c_in = ci;
    sub_drv = sb;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
      if (ok) return;
    end
    check("send_timeout", 64'(0), 64'(1));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] r;
    case ($urandom_range(0, 5))
      0: r = '0;
      1: r = '1;
      2: r = 16'h8000;
      3: r = 16'h7FFF;
      default: r = W'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    int s0, c0;
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.c_in = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_c_out", 64'(bus.c_out), 64'(0));
    check("rst_ovf", 64'(bus.overflow), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Single beat.
    send(16'hDDDD, 16'h8888, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    repeat (S + 2) step();
    check("t1_sum", 64'(last_sum), 64'h6666);
    check("t1_c_out", 64'(last_c), 64'(1));
    check("t1_ovf", 64'(last_v), 64'(1));

    // Back-to-back pair.
    send(16'hDDDD, 16'h8888, 1'b1, 1'b0);
    send(16'hAAAA, 16'h9999, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (S + 2) step();
    check("t2_first_sum", 64'(prev_sum), 64'h6666);
    check("t2_first_c", 64'(prev_c), 64'(1));
    check("t2_first_ovf", 64'(prev_v), 64'(1));
    check("t2_second_sum", 64'(last_sum), 64'h4443);
    check("t2_second_c", 64'(last_c), 64'(1));
    check("t2_second_ovf", 64'(last_v), 64'(1));
    check("t2_consecutive", 64'(last_cyc - prev_cyc), 64'(1));

    // Carry across every stage boundary.
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    repeat (S + 2) step();
    check("t3_sum", 64'(last_sum), 64'h0000);
    check("t3_c_out", 64'(last_c), 64'(1));
    check("t3_ovf", 64'(last_v), 64'(0));

    // Five beats with a three-cycle downstream stall.
    s0 = stall_cnt;
    c0 = consumed;
    fork
      begin
        for (int i = 0; i < 5; i++) send(pick(), pick(), 1'($urandom), 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) step();
        bus.out_ready = 1'b0;
        repeat (3) step();
        bus.out_ready = 1'b1;
      end
    join
    repeat (S + 6) step();
    check("t4_stall_cycles", 64'(stall_cnt - s0), 64'(3));
    check("t4_delivered", 64'(consumed - c0), 64'(5));

    // Reset discards in-flight beat and a beat presented during reset.
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in1 = 16'h0F0F;
    bus.in2 = 16'h0101;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_in_ready", 64'(bus.in_ready), 64'(1));
    check("t5_out_valid", 64'(bus.out_valid), 64'(0));
    c0 = consumed;
    repeat (S + 4) step();
    check("t5_no_results", 64'(consumed - c0), 64'(0));

`ifdef SUB_MODE_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    repeat (S + 2) step();
    check("t6_sub_sum", 64'(last_sum), 64'hFFFE);
    check("t6_sub_c", 64'(last_c), 64'(0));
    check("t6_sub_ovf", 64'(last_v), 64'(0));
`endif

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in1 = pick();
      bus.in2 = pick();
      bus.c_in = 1'($urandom);
`ifdef SUB_MODE_EN
      sub_drv = 1'($urandom);
`endif
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 200 && q.size() > 0; t++) step();
    step();
    check("drain_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/sum width in bits; legal values 4 to 64.
REQ-002 Parameter STAGES, default 4, pipeline stages; legal values 1 to WIDTH, and WIDTH SHALL be divisible by STAGES (SEG = WIDTH/STAGES bits per stage).
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in1  input  WIDTH  operand A.
REQ-008 in2  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry-in.
REQ-010 sub  input  1  subtract select (present only with SUB_MODE_EN).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  carry-out of the MSB.
REQ-015 overflow  output  1  two's-complement signed overflow.

Function
REQ-016 The block SHALL be a STAGES-deep ripple-carry pipeline: stage k adds bits [k*SEG +: SEG] using the registered carry from stage k-1, and stage 0 uses the effective carry-in.
REQ-017 Stage k SHALL carry forward the unconsumed upper operand segments and the completed lower sum segments, so that sum is bit-exact to (in1 + in2 + c_in) mod 2^WIDTH.
REQ-018 Handshake: a beat is accepted when in_valid && in_ready, and a result is consumed when out_valid && out_ready.
REQ-019 Global enable: adv = !(out_valid && !out_ready), in_ready = adv, and all stage registers, including valid bits, SHALL shift only when adv is 1.
REQ-020 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when there are no stalls.
REQ-021 Throughput SHALL be one beat per cycle with out_ready held at 1.
REQ-022 Cycles without an accepted beat SHALL insert a bubble (stage valid 0); bubbles SHALL NOT raise out_valid.
REQ-023 During a stall (adv 0), sum, c_out, overflow and out_valid SHALL hold stable, and no beat is lost or duplicated.
REQ-024 c_out SHALL be the carry out of bit WIDTH-1, and overflow SHALL equal the carry into bit WIDTH-1 XOR c_out.
REQ-025 Carry SHALL propagate across all stage boundaries; there is no wrap-around of carry into bit 0.
REQ-026 in1, in2, c_in and sub SHALL be ignored when in_valid is 0.

Reset
REQ-027 On reset, all stage valid bits SHALL clear, and out_valid, sum, c_out and overflow SHALL be 0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight beats, and no result SHALL emerge for them afterward.
REQ-030 Reset SHALL take priority over acceptance in the same cycle, so a beat presented with reset high is dropped.

Configuration
REQ-031 Macro SUB_MODE_EN: when defined, the sub port exists, and sub = 1 captures operand B as ~in2 with an effective carry-in of 1 (c_in ignored), so sum = in1 - in2 and c_out = 1 means no borrow.
REQ-032 Without SUB_MODE_EN, the sub port is absent and the block adds only.

Verification (WIDTH=16, STAGES=4 unless noted)
REQ-033 in1=0xDDDD, in2=0x8888, c_in=1, out_ready=1 -> 4 cycles later sum=0x6666, c_out=1, overflow=1.
REQ-034 Back-to-back beats 0xDDDD+0x8888+1, then 0xAAAA+0x9999+0 -> results on consecutive cycles: 0x6666/c_out 1/overflow 1, then 0x4443/c_out 1/overflow 1.
REQ-035 in1=0xFFFF, in2=0x0000, c_in=1 -> sum=0x0000, c_out=1, overflow=0 (carry crosses all 3 stage boundaries).
REQ-036 Five back-to-back beats with out_ready=0 for cycles 5-7 -> in_ready=0 and outputs frozen for 3 cycles, then all five results emerge in order with no loss.
REQ-037 reset pulsed 2 cycles after accepting a beat -> out_valid stays 0 until new beats are issued, and in_ready=1 the cycle after reset.
REQ-038 With SUB_MODE_EN: in1=0x0005, in2=0x0007, sub=1 -> sum=0xFFFE, c_out=0, overflow=0; with STAGES=1 and STAGES=16 the same vectors give identical results at latencies 1 and 16.
